// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequence transmitter.
package gray_pkg;

  localparam int DEF_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Fixed-width reference encoder; gray_enc provides the width-parameterised version.
  function automatic logic [DEF_W-1:0] bin2gray(input logic [DEF_W-1:0] bin);
    return bin ^ (bin >> 1'b1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder of parameterised width.
module gray_enc
  import gray_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1'b1);

endmodule

// File: rtl/gray_seq_tx.sv
// Streaming Gray-code transmitter with load, up/down stepping and one-shot/wrap modes.
// Optional parity output enabled by defining GRAY_PARITY_EN.
module gray_seq_tx
  import gray_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] gray_out,
  output logic [W-1:0] bin_out,
  output logic         wrap,
  output logic         done
`ifdef GRAY_PARITY_EN
  ,
  output logic         parity
`endif
);

  localparam logic [W-1:0] BIN_ZERO = {W{1'b0}};
  localparam logic [W-1:0] BIN_MAX  = {W{1'b1}};
  localparam logic [W-1:0] BIN_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [W-1:0]   gray_q, gray_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;
  logic           done_q, done_d;
  logic           beat_s;
  logic           terminal_s;
  logic [W-1:0]   step_s;

  assign beat_s     = valid_q & out_ready;
  assign terminal_s = dir ? (bin_q == BIN_ZERO) : (bin_q == BIN_MAX);
  assign step_s     = dir ? (bin_q - BIN_ONE) : (bin_q + BIN_ONE);

  // Encoding the next count keeps gray_out aligned with bin_out on the same edge.
  gray_enc #(.W(W)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (load) begin
          bin_d = load_val;
        end else begin
          bin_d = bin_q;
        end
        if (start) begin
          state_d = COUNT;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (beat_s) begin
          bin_d  = step_s;
          wrap_d = terminal_s;
          if (ONE_SHOT && terminal_s) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end else begin
          bin_d = bin_q;
        end
        // A same-cycle beat has already advanced the counter above.
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          valid_d = valid_d;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef GRAY_PARITY_EN
  logic parity_q;
  logic parity_d;

  assign parity_d = ^gray_d;
  assign parity   = parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= BIN_ZERO;
      gray_q  <= BIN_ZERO;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_tx.sv
// Bench for gray_seq_tx: a wrapping and a one-shot instance share stimulus and are
// checked every cycle against a counter-level model, plus literal expectations.
module tb_gray_seq_tx;

  localparam int W = 4;

  typedef struct packed {
    bit       run;
    bit [3:0] bin;
    bit       wrap;
    bit       done;
  } m_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = 4'd0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         dir = 1'b0;
  logic         out_ready = 1'b0;

  logic         valid_a, wrap_a, done_a;
  logic [W-1:0] gray_a, bin_a;
  logic         valid_b, wrap_b, done_b;
  logic [W-1:0] gray_b, bin_b;
`ifdef GRAY_PARITY_EN
  logic         parity_a, parity_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  m_t ma, mb;

  int gray_tbl [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  gray_seq_tx #(.W(W), .ONE_SHOT(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .dir(dir), .out_valid(valid_a), .out_ready(out_ready),
    .gray_out(gray_a), .bin_out(bin_a), .wrap(wrap_a), .done(done_a)
`ifdef GRAY_PARITY_EN
    , .parity(parity_a)
`endif
  );

  gray_seq_tx #(.W(W), .ONE_SHOT(1'b1)) dut_os (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .dir(dir), .out_valid(valid_b), .out_ready(out_ready),
    .gray_out(gray_b), .bin_out(bin_b), .wrap(wrap_b), .done(done_b)
`ifdef GRAY_PARITY_EN
    , .parity(parity_b)
`endif
  );

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Counter-level reference: what the stream must do for one clock given the inputs.
  function automatic m_t mstep(input m_t s, input bit os, input bit ld, input bit [3:0] lv,
                               input bit st, input bit sp, input bit dr, input bit rd);
    m_t n;
    int v;
    n = s;
    n.wrap = 1'b0;
    n.done = 1'b0;
    v = int'(s.bin);
    if (!s.run) begin
      if (ld) n.bin = lv;
      if (st) n.run = 1'b1;
    end else begin
      if (rd) begin
        n.wrap = dr ? (v == 0) : (v == 15);
        n.bin = 4'(dr ? (v + 15) % 16 : (v + 1) % 16);
        if (os && n.wrap) begin
          n.run = 1'b0;
          n.done = 1'b1;
        end
      end
      if (sp) n.run = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, 1'b0, load, load_val, start, stop, dir, out_ready);
      mb <= mstep(mb, 1'b1, load, load_val, start, stop, dir, out_ready);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input m_t m, input logic v, input logic [3:0] b,
                     input logic [3:0] g, input logic wr, input logic dn);
    check({tag, ".out_valid"}, int'(v), int'(m.run));
    check({tag, ".bin_out"}, int'(b), int'(m.bin));
    check({tag, ".gray_out"}, int'(g), to_gray(int'(m.bin)));
    check({tag, ".wrap"}, int'(wr), int'(m.wrap));
    check({tag, ".done"}, int'(dn), int'(m.done));
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("a", ma, valid_a, bin_a, gray_a, wrap_a, done_a);
    cmp("b", mb, valid_b, bin_b, gray_b, wrap_b, done_b);
`ifdef GRAY_PARITY_EN
    check("a.parity", int'(parity_a), int'(^gray_a));
    check("b.parity", int'(parity_b), int'(^to_gray(int'(mb.bin))));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_valid", int'(valid_a), 0);
    check("rst_bin", int'(bin_a), 0);
    rst = 1'b0;
    tick();

    // Load latency
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    check("load_bin", int'(bin_a), 5);
    check("load_gray", int'(gray_a), 7);
    check("load_idle_valid", int'(valid_a), 0);

    // Up run over the full code space
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; start = 1'b1; dir = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("up_seq", int'(gray_a), gray_tbl[i]);
      tick();
    end
    check("up_wrap", int'(wrap_a), 1);
    check("up_after_wrap", int'(gray_a), 0);
    check("os_up_done", int'(done_b), 1);
    check("os_up_valid", int'(valid_b), 0);

    // Backpressure at gray 3
    repeat (2) tick();
    check("bp_start", int'(gray_a), 3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_gray", int'(gray_a), 3);
      check("bp_hold_valid", int'(valid_a), 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", int'(gray_a), 2);

    // Stop with a same-cycle beat
    repeat (3) tick();
    check("stop_pre", int'(bin_a), 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_bin", int'(bin_a), 7);
    check("stop_valid", int'(valid_a), 0);

    // Down one-shot from 2
    load = 1'b1; load_val = 4'd2; start = 1'b1; dir = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check("os_c0", int'(gray_b), 3);
    tick();
    check("os_c1", int'(gray_b), 1);
    tick();
    check("os_c2", int'(gray_b), 0);
    tick();
    check("os_done", int'(done_b), 1);
    check("os_valid", int'(valid_b), 0);
    check("os_bin", int'(bin_b), 15);
    check("down_wrap", int'(wrap_a), 1);
    dir = 1'b0;

    // Asynchronous reset mid-stream
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_bin", int'(bin_a), 0);
    check("arst_gray", int'(gray_a), 0);
    check("arst_valid", int'(valid_a), 0);
    tick();
    rst = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 3) == 0);
      load_val  = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 4) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      dir       = ($urandom_range(0, 5) == 0) ? ~dir : dir;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
